// File: rtl/arb_requester_if.sv
// Job-push, arbiter req/gnt and beat-status bundle for one arb_requester port.
// slave = the requester block itself, master = the job source / arbiter side.
interface arb_requester_if #(
    parameter int LEN_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
);
    logic                          job_valid;
    logic [LEN_WIDTH-1:0]          job_len;
    logic                          job_ready;
    logic                          req;
    logic                          gnt;
    logic                          beat_valid;
    logic [LEN_WIDTH-1:0]          beat_idx;
    logic                          beat_last;
    logic                          done;
    logic                          err_abort;
    logic                          err_timeout;
    logic                          busy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    modport slave (
        input  job_valid, job_len, gnt,
        output job_ready, req, beat_valid, beat_idx, beat_last,
               done, err_abort, err_timeout, busy, fifo_level
    );

    modport master (
        output job_valid, job_len, gnt,
        input  job_ready, req, beat_valid, beat_idx, beat_last,
               done, err_abort, err_timeout, busy, fifo_level
    );
endinterface

// File: rtl/arb_requester.sv
// arb_requester: queues transfer jobs and runs the req/gnt handshake with a one-hot arbiter.
// Latency: push into empty queue -> req 2 cycles later; beats start the cycle after gnt is seen.
// Backpressure: job_ready = !full; grant-wait timeout only when ARB_REQ_TIMEOUT_EN is defined.
module arb_requester #(
    parameter int LEN_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic           clk,
    input  logic           rstn,
    arb_requester_if.slave bus
);

    localparam int          PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] LVL_FULL = (PW + 1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_cfg
        $error("arb_requester: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [PW:0]          r_level;
    logic [LEN_WIDTH-1:0] r_cur_len;
    logic [LEN_WIDTH-1:0] r_beat_idx;
    logic                 r_req;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_beat;
    logic                 w_done;
    logic                 w_abort;
    logic                 w_tmo;

    assign w_full = (r_level == LVL_FULL);
    assign w_push = bus.job_valid && !w_full;
    assign w_pop  = (r_state == IDLE) && (r_level != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.job_len;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int          TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] r_tcnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tcnt <= '0;
        end else if (w_pop) begin
            r_tcnt <= '0;
        end else if (r_state == REQ && !bus.gnt) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign w_tmo = (r_state == REQ) && !bus.gnt && (r_tcnt == TMO_LAST);
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: if (r_level != '0) w_state_nxt = REQ;
            REQ: begin
                // The grant-seen cycle is not a beat; XFER starts counting next cycle.
                if (bus.gnt)    w_state_nxt = XFER;
                else if (w_tmo) w_state_nxt = REL;
            end
            XFER: begin
                if (bus.gnt) begin
                    w_beat = 1'b1;
                    if (r_beat_idx == r_cur_len) begin
                        w_done      = 1'b1;
                        w_state_nxt = REL;
                    end
                end else begin
                    w_abort     = 1'b1;
                    w_state_nxt = REL;
                end
            end
            REL:     if (!bus.gnt) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_cur_len  <= '0;
            r_beat_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == REQ) || (w_state_nxt == XFER);
            if (w_pop) begin
                r_cur_len  <= r_mem[r_rptr];
                r_beat_idx <= '0;
            end else if (w_beat) begin
                r_beat_idx <= r_beat_idx + 1'b1;
            end
        end
    end

    assign bus.job_ready   = !w_full;
    assign bus.req         = r_req;
    assign bus.beat_valid  = w_beat;
    assign bus.beat_idx    = r_beat_idx;
    assign bus.beat_last   = w_done;
    assign bus.done        = w_done;
    assign bus.err_abort   = w_abort;
    assign bus.err_timeout = w_tmo;
    assign bus.busy        = (r_state != IDLE);
    assign bus.fifo_level  = r_level;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: random jobs, behavioural arbiter with optional mid-transfer grant drops,
// and a scoreboard of queued jobs checked against every beat/done/abort the DUT reports.
module tb_arb_requester;

    localparam int LW    = 4;
    localparam int DEPTH = 4;

    typedef struct {
        int len;
        int abort_at;   // beat index at which the arbiter pulls gnt, -1 = never
    } job_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    arb_requester_if #(.LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)) bus ();

    arb_requester #(.LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH), .TIMEOUT(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    job_t sb_q[$];
    job_t drv_q[$];
    job_t cur;
    job_t new_job;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stim_abort = -1;
    int   model_cnt = 0;
    int   cur_beat = 0;
    int   exp_done_jobs = 0;
    int   exp_abort_jobs = 0;
    int   got_done = 0;
    int   got_abort = 0;
    bit   prev_push = 0;
    bit   prev_req = 0;
    bit   cur_act = 0;
    bit   exp_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: queue-occupancy model plus per-job beat scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            model_cnt = 0;
            prev_push = 0;
            prev_req  = 0;
            cur_act   = 0;
            sb_q.delete();
        end else begin
            if (prev_push) model_cnt++;
            if (bus.req && !prev_req) model_cnt--;
            prev_req = bus.req;
            check("fifo_level", bus.fifo_level, model_cnt);
            check("job_ready", bus.job_ready, model_cnt < DEPTH);
            prev_push = bus.job_valid && (model_cnt < DEPTH);
            if (prev_push) begin
                new_job.len      = int'(bus.job_len);
                new_job.abort_at = stim_abort;
                sb_q.push_back(new_job);
                drv_q.push_back(new_job);
                if (stim_abort < 0) exp_done_jobs++;
                else                exp_abort_jobs++;
            end

            if (bus.beat_valid || bus.done || bus.err_abort) begin
                if (!cur_act) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_event", 1, 0);
                    end else begin
                        cur      = sb_q.pop_front();
                        cur_act  = 1;
                        cur_beat = 0;
                    end
                end
                if (cur_act) begin
                    exp_last = 0;
                    if (bus.beat_valid) begin
                        check("beat_idx", bus.beat_idx, cur_beat);
                        exp_last = (cur_beat == cur.len);
                        check("beat_last", bus.beat_last, exp_last);
                        cur_beat++;
                    end
                    check("done", bus.done, exp_last);
                    check("err_abort", bus.err_abort,
                          !bus.beat_valid && (cur.abort_at == cur_beat));
                    if (bus.done) begin
                        got_done++;
                        cur_act = 0;
                    end
                    if (bus.err_abort) begin
                        got_abort++;
                        cur_act = 0;
                    end
                end
            end
        end
    end

    // Arbiter model: grants after a random 0..2 cycle wait, holds while req is high,
    // drops one cycle after req falls, and pulls gnt early when a job plans an abort.
    initial begin
        int   st;
        int   wait_cnt;
        int   gcyc;
        job_t plan;
        bit   r;
        bit   nxt;
        st            = 0;
        wait_cnt      = 0;
        gcyc          = 0;
        plan.len      = 0;
        plan.abort_at = -1;
        bus.gnt       = 1'b0;
        forever begin
            @(negedge clk);
            r   = bus.req;
            nxt = 0;
            if (!rstn) begin
                st = 0;
                drv_q.delete();
            end else begin
                case (st)
                    0: begin
                        if (r) begin
                            if (wait_cnt == 0) begin
                                nxt  = 1;
                                st   = 1;
                                gcyc = 0;
                                if (drv_q.size() > 0) plan = drv_q.pop_front();
                                else                  plan.abort_at = -1;
                            end else begin
                                wait_cnt--;
                            end
                        end else begin
                            wait_cnt = $urandom_range(0, 2);
                        end
                    end
                    1: begin
                        if (!r) begin
                            st       = 0;
                            wait_cnt = $urandom_range(0, 2);
                        end else begin
                            gcyc++;
                            // Grant cycle 0 is the REQ cycle, so beat b rides on grant cycle b+1.
                            if (plan.abort_at >= 0 && gcyc == plan.abort_at + 1) st = 2;
                            else nxt = 1;
                        end
                    end
                    default: begin
                        if (!r) begin
                            st       = 0;
                            wait_cnt = $urandom_range(0, 2);
                        end
                    end
                endcase
            end
            @(posedge clk);
            #1;
            bus.gnt = rstn ? nxt : 1'b0;
        end
    end

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        bus.job_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            if (model_cnt == 0 && sb_q.size() == 0 && !cur_act && !bus.busy) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    initial begin
        int  len;
        bit  seen;
        bus.job_valid = 1'b0;
        bus.job_len   = '0;
        rstn          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_job_ready", bus.job_ready, 1);
        check("rst_req", bus.req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_level", bus.fifo_level, 0);
        check("rst_beat_valid", bus.beat_valid, 0);
        check("rst_done", bus.done, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Single len=3 job: req must rise exactly two cycles after the push cycle.
        @(posedge clk);
        #1;
        bus.job_valid = 1'b1;
        bus.job_len   = 4'd3;
        stim_abort    = -1;
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        @(negedge clk);
        check("lat_req_low", bus.req, 0);
        @(negedge clk);
        check("lat_req_high", bus.req, 1);
        check("lat_busy", bus.busy, 1);
        drain("drain_single");

        // Random traffic, heavy enough to fill the queue and exercise backpressure.
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            bus.job_valid = ($urandom_range(0, 2) != 0);
            len = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 15));
            bus.job_len = LW'(len);
            stim_abort  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
        end
        drain("drain_random");
        check("done_count", got_done, exp_done_jobs);
        check("abort_count", got_abort, exp_abort_jobs);
        check("idle_req", bus.req, 0);

        // Asynchronous reset in the middle of a long transfer.
        @(posedge clk);
        #1;
        bus.job_valid = 1'b1;
        bus.job_len   = 4'hF;
        stim_abort    = -1;
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (bus.beat_valid) begin
                seen = 1;
                break;
            end
        end
        check("xfer_reached", seen, 1);
        #1;
        rstn = 1'b0;
        #1;
        check("arst_req", bus.req, 0);
        check("arst_beat_valid", bus.beat_valid, 0);
        check("arst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #2;
        check("post_rst_level", bus.fifo_level, 0);
        check("post_rst_ready", bus.job_ready, 1);

        // The block must take a fresh job normally after reset.
        @(posedge clk);
        #1;
        bus.job_valid = 1'b1;
        bus.job_len   = 4'd2;
        stim_abort    = -1;
        @(posedge clk);
        #1;
        bus.job_valid = 1'b0;
        drain("drain_post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
